danger_spawner: RTL and testbench

//  Produces the obstacle position bus consumed by the danger sprite renderer.

---
 rtl/danger_spawner.sv | 117 +++++++++++
 tb/tb_danger_spawner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/danger_spawner.sv
// Obstacle spawner for the runner game: waits a pseudo-random number of frame
// ticks, spawns one obstacle at the right edge, scrolls it left and retires it.
module danger_spawner #(
  parameter int          SCREEN_W  = 320,
  parameter int          WIDTH     = 26,
  parameter int          SPEED     = 2,
  parameter int          DINO_X    = 40,
  parameter int          GAP_MIN   = 30,
  parameter int          GAP_MASK  = 63,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       freeze,
  output logic [8:0] pos,
  output logic       active,
  output logic       passed
);

  if (SCREEN_W + WIDTH > 511) begin : g_bad_width
    $error("danger_spawner: SCREEN_W+WIDTH must fit in 9 bits");
  end
  if (GAP_MIN + GAP_MASK > 255) begin : g_bad_gap
    $error("danger_spawner: GAP_MIN+GAP_MASK must fit in 8 bits");
  end
  if (SPEED < 1) begin : g_bad_speed
    $error("danger_spawner: SPEED must be at least 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("danger_spawner: LFSR_SEED must be nonzero");
  end

  localparam logic [8:0] SPAWN_POS  = 9'(SCREEN_W + WIDTH);
  localparam logic [8:0] SPEED_STEP = 9'(SPEED);
  localparam logic [8:0] DINO_POS   = 9'(DINO_X);
  localparam logic [7:0] GAP_BASE   = 8'(GAP_MIN);
  localparam logic [7:0] GAP_SPAN   = 8'(GAP_MASK);

  typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

  state_t     state_reg, state_next;
  logic [7:0] gap_reg, gap_next;
  logic [7:0] lfsr_reg, lfsr_next;
  logic [8:0] pos_next;
  logic       active_next;
  logic       passed_next;
  logic [7:0] gap_load;
  logic [8:0] pos_dec;

  // Taps x^8+x^6+x^5+x^4+1: maximal length, so a nonzero seed never hits 0.
  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  assign gap_load  = GAP_BASE + (lfsr_reg & GAP_SPAN);
  assign pos_dec   = pos - SPEED_STEP;

  always_comb begin
    state_next  = state_reg;
    gap_next    = gap_reg;
    pos_next    = pos;
    active_next = active;
    passed_next = 1'b0;
    if (!enable) begin
      state_next  = IDLE;
      pos_next    = 9'd0;
      active_next = 1'b0;
    end else if (!freeze && tick) begin
      case (state_reg)
        IDLE: begin
          gap_next   = gap_load;
          state_next = WAIT;
        end
        WAIT: begin
          if (gap_reg != 8'd0) begin
            gap_next = gap_reg - 8'd1;
          end else begin
            pos_next    = SPAWN_POS;
            active_next = 1'b1;
            state_next  = RUN;
          end
        end
        RUN: begin
          if (pos <= SPEED_STEP) begin
            pos_next    = 9'd0;
            active_next = 1'b0;
            gap_next    = gap_load;
            state_next  = WAIT;
          end else begin
            pos_next = pos_dec;
          end
          // Strict crossing test makes the pulse fire once per obstacle.
          passed_next = (pos > DINO_POS) && (((pos <= SPEED_STEP) ? 9'd0 : pos_dec) <= DINO_POS);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gap_reg   <= 8'd0;
      lfsr_reg  <= LFSR_SEED;
      pos       <= 9'd0;
      active    <= 1'b0;
      passed    <= 1'b0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      lfsr_reg  <= lfsr_next;
      pos       <= pos_next;
      active    <= active_next;
      passed    <= passed_next;
    end
  end

endmodule

// File: tb/tb_danger_spawner.sv
// Bench for danger_spawner: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_danger_spawner;

  localparam int SCREEN_W = 320;
  localparam int WIDTH    = 26;
  localparam int SPEED    = 2;
  localparam int DINO_X   = 40;
  localparam int GAP_MIN  = 30;
  localparam int GAP_MASK = 63;
  localparam int SEED     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       freeze = 1'b0;
  logic [8:0] pos;
  logic       active;
  logic       passed;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: phase 0 = no obstacle pending, 1 = counting gap, 2 = obstacle on screen.
  int m_phase = 0;
  int m_pos = 0;
  int m_active = 0;
  int m_passed = 0;
  int m_gap = 0;
  int m_lfsr = SEED;

  danger_spawner dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .freeze(freeze),
    .pos(pos), .active(active), .passed(passed)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) & 8'hFF) | fb;
  endfunction

  task automatic model_update(input bit r, input bit en, input bit fz, input bit tk);
    int old_l;
    int np;
    if (r) begin
      m_phase = 0; m_pos = 0; m_active = 0; m_passed = 0; m_gap = 0; m_lfsr = SEED;
      return;
    end
    old_l    = m_lfsr;
    m_lfsr   = lfsr_step(m_lfsr);
    m_passed = 0;
    if (!en) begin
      m_phase = 0; m_pos = 0; m_active = 0;
    end else if (!fz && tk) begin
      if (m_phase == 0) begin
        m_gap = GAP_MIN + (old_l & GAP_MASK);
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_gap > 0) m_gap = m_gap - 1;
        else begin m_pos = SCREEN_W + WIDTH; m_active = 1; m_phase = 2; end
      end else begin
        np = (m_pos <= SPEED) ? 0 : m_pos - SPEED;
        if (m_pos > DINO_X && np <= DINO_X) m_passed = 1;
        if (np == 0) begin
          m_active = 0; m_phase = 1; m_gap = GAP_MIN + (old_l & GAP_MASK);
        end
        m_pos = np;
      end
    end
  endtask

  // One clock: drive at negedge, step model at posedge, return 3 time units later.
  task automatic cyc(input bit r, input bit en, input bit fz, input bit tk);
    @(negedge clk);
    rst = r; enable = en; freeze = fz; tick = tk;
    @(posedge clk);
    model_update(r, en, fz, tk);
    cmp_en = 1'b1;
    #3;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      checks++;
      if (int'(pos) != m_pos || int'(active) != m_active || int'(passed) != m_passed) begin
        failures++;
        $display("FAIL model t=%0t: pos=%0d active=%0d passed=%0d expected pos=%0d active=%0d passed=%0d",
                 $time, pos, active, passed, m_pos, m_active, m_passed);
      end
    end
  end

  task automatic ticks_until_active(input string nm, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
      if (active) break;
    end
    if (!active) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic ticks_until_pos(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (int'(pos) != target && n < budget) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    if (int'(pos) != target) chk({nm, "_timeout"}, int'(pos), target);
  endtask

  initial begin
    int n;
    int pcnt;
    int ppos;
    int frz_bad;

    // Reset with tick toggling.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset_pos", int'(pos), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_pos2", int'(pos), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_passed", int'(passed), 0);

    // First gap uses the seed: 30 + (0xA5 & 63) = 67 -> 1 + 67 + 1 ticks to spawn.
    ticks_until_active("spawn", 200, n);
    chk("spawn_ticks", n, 69);
    chk("spawn_pos", int'(pos), 346);

    // Full scroll.
    n = 0; pcnt = 0; ppos = -1;
    while (n < 400) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
      if (n == 1) chk("scroll_first", int'(pos), 344);
      if (passed) begin pcnt++; ppos = int'(pos); end
      if (!active) break;
    end
    chk("scroll_ticks", n, 173);
    chk("scroll_end_pos", int'(pos), 0);
    chk("passed_count", pcnt, 1);
    chk("passed_pos", ppos, 40);

    // Freeze hold at 200.
    ticks_until_active("respawn", 300, n);
    ticks_until_pos("to200", 200, 200);
    frz_bad = 0;
    repeat (10) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      if (pos != 9'd200 || passed) frz_bad++;
    end
    chk("freeze_hold", frz_bad, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("freeze_notick", int'(pos), 200);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("freeze_release", int'(pos), 198);

    // Enable drop at 120.
    ticks_until_pos("to120", 120, 200);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("disable_pos", int'(pos), 0);
    chk("disable_active", int'(active), 0);
    ticks_until_active("reenable", 300, n);
    chk("reenable_pos", int'(pos), 346);

    // Reset racing a tick at pos 60.
    ticks_until_pos("to60", 60, 200);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("race_pos", int'(pos), 0);
    chk("race_active", int'(active), 0);
    ticks_until_active("race_spawn", 200, n);
    chk("race_spawn_ticks", n, 69);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom % 1500) == 0, ($urandom % 300) != 0, ($urandom % 16) == 0, ($urandom % 2) == 0);
    end

    cmp_en = 1'b0;
    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
